// File: rtl/alu_iter_exec_pkg.sv
// Shared ALUop codes, shifter direction select and op-class helpers for the execute ALU.
package alu_iter_exec_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRA    = 4'd8,
    ALU_SRL    = 4'd9,
    ALU_COPY_B = 4'd10,
    ALU_COPY_A = 4'd11,
    ALU_XXX    = 4'd15
  } alu_op_e;

  // bit0 = shift right, bit1 = arithmetic (sign fill)
  typedef enum logic [1:0] {
    SH_LEFT      = 2'b00,
    SH_RIGHT_LOG = 2'b01,
    SH_RIGHT_ARI = 2'b11
  } shift_dir_e;

  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic shift_dir_e shift_dir(input logic [OP_W-1:0] op);
    shift_dir_e d;
    d = SH_LEFT;
    if (op == ALU_SRL) d = SH_RIGHT_LOG;
    if (op == ALU_SRA) d = SH_RIGHT_ARI;
    return d;
  endfunction

endpackage

// File: rtl/alu_iter_exec_if.sv
// Issue/result handshake bundle between operand-select, the execute ALU and writeback.
interface alu_iter_exec_if #(
  parameter int unsigned WIDTH = 32
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [alu_iter_exec_pkg::OP_W-1:0]    alu_op;
  logic [WIDTH-1:0]                      a;
  logic [WIDTH-1:0]                      b;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [WIDTH-1:0]                      result;
  logic                                  illegal;

  modport master (
    output in_valid, alu_op, a, b, out_ready,
    input  in_ready, out_valid, result, illegal
  );

  modport slave (
    input  in_valid, alu_op, a, b, out_ready,
    output in_ready, out_valid, result, illegal
  );
endinterface

// File: rtl/alu_iter_exec_serial_shifter.sv
// One-bit-per-cycle shifter: load captures operand, count and direction; each step shifts once.
module alu_iter_exec_serial_shifter
  import alu_iter_exec_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [SHW-1:0]   i_shamt,
  input  shift_dir_e       i_dir,
  output logic [WIDTH-1:0] o_shifted_c,
  output logic             o_done_c
);

  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  shift_dir_e       r_dir;
  logic [WIDTH-1:0] w_shifted;

  // Accumulator, remaining count and direction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_dir <= SH_LEFT;
    end else if (i_load) begin
      r_acc <= i_a;
      r_cnt <= i_shamt;
      r_dir <= i_dir;
    end else if (i_step) begin
      r_acc <= w_shifted;
      r_cnt <= r_cnt - SHW'(1);
    end
  end

  // Single-bit shift of the accumulator; arithmetic right replicates the sign bit
  always_comb begin
    w_shifted = {r_acc[WIDTH-2:0], 1'b0};
    case (r_dir)
      SH_RIGHT_LOG: w_shifted = {1'b0, r_acc[WIDTH-1:1]};
      SH_RIGHT_ARI: w_shifted = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      default:      w_shifted = {r_acc[WIDTH-2:0], 1'b0};
    endcase
  end

  assign o_shifted_c = w_shifted;
  assign o_done_c    = (r_cnt == SHW'(1));

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops, serial shifts, valid/ready on both sides.
module alu_iter_exec
  import alu_iter_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_iter_exec_if.slave bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_illegal;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_shift;
  logic             w_go_shift;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_alu;
  logic             w_alu_ill;
  logic             w_load;
  logic             w_step;
  logic             w_res_we;
  logic [WIDTH-1:0] w_res_d;
  logic             w_ill_d;
  logic [WIDTH-1:0] w_shifted;
  logic             w_sh_done;

  assign w_in_ready = rst_n & ((r_state == S_IDLE) | ((r_state == S_DONE) & bus.out_ready));
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_is_shift = is_shift_op(bus.alu_op);
  assign w_shamt    = bus.b[SHW-1:0];
  assign w_go_shift = w_is_shift & (w_shamt != '0);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.illegal   = r_illegal;

  // Single-cycle result; shifts with zero amount pass operand A through
  always_comb begin
    w_alu     = '0;
    w_alu_ill = 1'b0;
    case (bus.alu_op)
      ALU_ADD:    w_alu = bus.a + bus.b;
      ALU_SUB:    w_alu = bus.a - bus.b;
      ALU_AND:    w_alu = bus.a & bus.b;
      ALU_OR:     w_alu = bus.a | bus.b;
      ALU_XOR:    w_alu = bus.a ^ bus.b;
      ALU_SLT:    w_alu = WIDTH'($signed(bus.a) < $signed(bus.b));
      ALU_SLTU:   w_alu = WIDTH'(bus.a < bus.b);
      ALU_SLL,
      ALU_SRA,
      ALU_SRL:    w_alu = bus.a;
      ALU_COPY_B: w_alu = bus.b;
      ALU_COPY_A: w_alu = bus.a;
      default:    w_alu_ill = 1'b1;
    endcase
  end

  alu_iter_exec_serial_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_a         (bus.a),
    .i_shamt     (w_shamt),
    .i_dir       (shift_dir(bus.alu_op)),
    .o_shifted_c (w_shifted),
    .o_done_c    (w_sh_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept)                             w_state_nxt = w_go_shift ? S_SHIFT : S_DONE;
        else if (r_state == S_DONE && bus.out_ready) w_state_nxt = S_IDLE;
      end
      S_SHIFT: if (w_sh_done) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control outputs: shifter load/step and result-register write
  always_comb begin
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_res_we = 1'b0;
    w_res_d  = '0;
    w_ill_d  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_load = w_accept & w_is_shift;
        if (w_accept && !w_go_shift) begin
          w_res_we = 1'b1;
          w_res_d  = w_alu;
          w_ill_d  = w_alu_ill;
        end
      end
      S_SHIFT: begin
        w_step = 1'b1;
        if (w_sh_done) begin
          w_res_we = 1'b1;
          w_res_d  = w_shifted;
        end
      end
      default: ;
    endcase
  end

  // Result and illegal flag hold steady until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else if (w_res_we) begin
      r_result  <= w_res_d;
      r_illegal <= w_ill_d;
    end
  end

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed bench for alu_iter_exec with hand-computed expectations.
module tb_alu_iter_exec;
  import alu_iter_exec_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   n;
  int   lo;

  alu_iter_exec_if #(.WIDTH(32)) bus ();

  alu_iter_exec #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.a        = a;
    bus.b        = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until out_valid; lo counts busy cycles with in_ready low
  task automatic wait_valid(output int cyc, output int low);
    cyc = 1;
    low = 0;
    while (!bus.out_valid && cyc < 200) begin
      if (!bus.in_ready) low++;
      tick();
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_ill);
    issue(op, a, b);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_illegal"}, 32'(bus.illegal), 32'(exp_ill));
    tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_op    = 4'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    #2;
    check("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_result", bus.result, 32'd0);
    check("post_rst_illegal", 32'(bus.illegal), 32'd0);

    // ADD wrap, then SUB/SLT/SLTU back-to-back with no bubble
    bus.in_valid = 1'b1;
    bus.alu_op = 4'd0; bus.a = 32'hFFFF_FFFF; bus.b = 32'd1;
    tick();
    check("add_valid", 32'(bus.out_valid), 32'd1);
    check("add_result", bus.result, 32'h0000_0000);
    check("add_illegal", 32'(bus.illegal), 32'd0);
    bus.alu_op = 4'd1; bus.a = 32'd5; bus.b = 32'd7;
    check("b2b_ready_sub", 32'(bus.in_ready), 32'd1);
    tick();
    check("sub_result", bus.result, 32'hFFFF_FFFE);
    bus.alu_op = 4'd5; bus.a = 32'h8000_0000; bus.b = 32'd1;
    check("b2b_ready_slt", 32'(bus.in_ready), 32'd1);
    tick();
    check("slt_result", bus.result, 32'd1);
    bus.alu_op = 4'd6;
    check("b2b_ready_sltu", 32'(bus.in_ready), 32'd1);
    tick();
    check("sltu_valid", 32'(bus.out_valid), 32'd1);
    check("sltu_result", bus.result, 32'd0);
    bus.in_valid = 1'b0;
    tick();
    check("drain_idle", 32'(bus.out_valid), 32'd0);

    // Plain logic and copy ops
    run_op("and", 4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0);
    run_op("or", 4'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0);
    run_op("xor", 4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0);
    run_op("copy_a", 4'd11, 32'hDEAD_BEEF, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0);

    // SRA by 31: 32-cycle latency, busy for 31 cycles
    issue(4'd8, 32'h8000_0000, 32'd31);
    wait_valid(n, lo);
    check("sra_latency", 32'(n), 32'd32);
    check("sra_ready_low", 32'(lo), 32'd31);
    check("sra_result", bus.result, 32'hFFFF_FFFF);
    tick();

    // SRL with b=0x20: shift amount 0 so result is A after one cycle
    issue(4'd9, 32'hA5A5_0F0F, 32'h0000_0020);
    wait_valid(n, lo);
    check("srl0_latency", 32'(n), 32'd1);
    check("srl0_result", bus.result, 32'hA5A5_0F0F);
    tick();

    // SLL 1<<4
    issue(4'd7, 32'd1, 32'd4);
    wait_valid(n, lo);
    check("sll_latency", 32'(n), 32'd5);
    check("sll_result", bus.result, 32'h0000_0010);
    tick();

    // SRL by 4 logical fill
    issue(4'd9, 32'h8000_00F0, 32'hFFFF_FFE4);
    wait_valid(n, lo);
    check("srl4_latency", 32'(n), 32'd5);
    check("srl4_result", bus.result, 32'h0800_000F);
    tick();

    // Backpressure in DONE, then release with a new op on the same edge
    bus.out_ready = 1'b0;
    issue(4'd4, 32'h0000_00F0, 32'h0000_00FF);
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_result", bus.result, 32'h0000_000F);
      check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b1;
    bus.alu_op = 4'd10; bus.a = 32'h5A5A_5A5A; bus.b = 32'h0000_1234;
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("copyb_valid", 32'(bus.out_valid), 32'd1);
    check("copyb_result", bus.result, 32'h0000_1234);
    tick();

    // Undefined ops and recovery
    run_op("op13", 4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1);
    run_op("opxxx", 4'd15, 32'h1, 32'h2, 32'd0, 1'b1);
    run_op("add_after_ill", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0);

    // Reset during a long shift
    issue(4'd7, 32'd1, 32'd20);
    for (int i = 0; i < 5; i++) tick();
    check("mid_shift_ready", 32'(bus.in_ready), 32'd0);
    check("mid_shift_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_result", bus.result, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_rel_ready", 32'(bus.in_ready), 32'd1);
    check("rst_rel_valid", 32'(bus.out_valid), 32'd0);
    run_op("post_rst_copya", 4'd11, 32'hCAFE_F00D, 32'd0, 32'hCAFE_F00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- Execute-stage ALU that consumes the 4-bit ALUop produced by the ALU decoder, together with operands A and B.
- Uses valid/ready handshakes on both input and output.
- Non-shift ops complete in one cycle.
- SLL/SRL/SRA run on an area-lean serial shifter at one bit per cycle, so latency depends on the shift amount.
- Sits between the decode/operand-select stage and writeback; it stalls upstream through in_ready.

Parameters:
- WIDTH, 32, datapath width; must be a power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept; handshake completes when in_valid && in_ready at a clk rising edge
- alu_op  input  4  ALUop encoding from ALUop.vh
- a  input  WIDTH  operand A (rs1/PC)
- b  input  WIDTH  operand B (rs2/imm); shift amount = b[SHW-1:0]
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts
- result  output  WIDTH  registered result
- illegal  output  1  registered; 1 when the accepted alu_op was undefined or ALU_XXX

Behaviour:
- ALUop encoding (ALUop.vh):
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRA=8, SRL=9, COPY_B=10, COPY_A=11.
  - XXX=15; codes 12-14 are undefined.
- State machine: IDLE, SHIFT, DONE.
  - Reset value is IDLE.
  - Reset values of outputs: out_valid=0, result=0, illegal=0.
  - in_ready is 0 while rst_n is low.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This permits back-to-back issue with no bubble.
- Accept in IDLE or DONE, non-shift op:
  - result <= f(a,b); illegal <= (op undefined); state -> DONE.
  - out_valid is high in the next cycle (latency 1).
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is a signed compare; SLTU is unsigned; both produce 0 or 1, zero-extended.
  - COPY_A -> a; COPY_B -> b.
  - Undefined op -> result=0, illegal=1.
- Accept, shift op (SLL/SRL/SRA):
  - Load acc=a, cnt=b[SHW-1:0].
  - If cnt==0: result=a and go to DONE (latency 1).
  - Otherwise go to SHIFT. Each cycle acc shifts by 1 (SRA replicates acc[WIDTH-1]) and cnt decrements.
  - When cnt==1, the shifted value is written to result and state -> DONE.
  - Latency is 1+shamt cycles, so the maximum is WIDTH cycles.
- Upper bits of b above SHW are ignored for shifts.
- DONE:
  - out_valid=1. result and illegal stay stable while out_ready is low.
  - If out_ready=1 and in_valid=0 -> IDLE.
  - If out_ready=1 and in_valid=1 -> accept the new op in the same cycle.
- in_ready is 0 throughout SHIFT; inputs presented then are ignored.
- Reset asserted mid-SHIFT or in DONE: immediately return to IDLE and clear out_valid/illegal/result. The pending op is lost.
- The unit never reads alu_op, a or b except on an accepting edge; operands are captured.

Decomposition:
- ALUop.vh (shared include): ALU_* codes, including the added ALU_COPY_A=11 and ALU_XXX=15; also used by ALUdec.
- The state encoding is localparam, private to this block.
- One sub-module: serial_shifter. It holds acc/cnt, load/step/done, and a 2-bit dir/arith select.
- Combinational ops and the FSM live in alu_iter_exec.

Test Plan:
- Post-reset: in_ready=1, out_valid=0.
- ADD: a=0xFFFFFFFF, b=1, out_ready=1 -> next cycle out_valid=1, result=0x00000000, illegal=0.
- SUB then SLT back-to-back: 5-7 gives 0xFFFFFFFE. SLT a=0x80000000, b=1 gives 1; SLTU with the same operands gives 0. Results arrive on consecutive cycles with in_ready held high.
- SRA: a=0x80000000, b=31 -> out_valid exactly 32 cycles after accept, result=0xFFFFFFFF. in_ready is 0 for 31 cycles.
- SRL with b=0x20 (shamt 0) -> latency 1, result=a.
- SLL a=1, b=4 -> result=0x10 after 5 cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result is stable and in_ready=0. On releasing out_ready with in_valid=1 (COPY_B, b=0x1234), the new op is accepted the same edge and result=0x1234 on the next cycle.
- Illegal/reset:
  - alu_op=13 -> result=0, illegal=1.
  - SLL with shamt 20, then drop rst_n at cycle 6 -> out_valid=0 and in_ready goes low at once. After release, state is IDLE and in_ready=1.
